// File: rtl/sdrc_rfsh_sched_if.sv
// Refresh handshake and status bundle between the refresh scheduler (master)
// and the transfer controller (slave).
interface sdrc_rfsh_sched_if #(
   parameter int unsigned TIMER_W   = 12,
   parameter int unsigned ROW_CNT_W = 3,
   parameter int unsigned PEND_W    = 4
);
   logic                 bus_idle;
   logic                 rfsh_ack;
   logic                 rfsh_req;
   logic                 rfsh_urgent;
   logic [PEND_W-1:0]    rfsh_pend;
   logic [ROW_CNT_W-1:0] rfsh_row_cnt;
   logic [TIMER_W-1:0]   rfsh_timer;
   logic                 rfsh_ovf;
   logic [15:0]          rfsh_total;

   modport master (
      input  bus_idle, rfsh_ack,
      output rfsh_req, rfsh_urgent, rfsh_pend, rfsh_row_cnt, rfsh_timer,
             rfsh_ovf, rfsh_total
   );

   modport slave (
      output bus_idle, rfsh_ack,
      input  rfsh_req, rfsh_urgent, rfsh_pend, rfsh_row_cnt, rfsh_timer,
             rfsh_ovf, rfsh_total
   );
endinterface

// File: rtl/sdrc_rfsh_sched.sv
// SDRAM refresh scheduler: interval timer, owed-credit counter and burst FSM.
// Optional feature macro: SDRC_RFSH_STATS_EN (enables the rfsh_total counter).
module sdrc_rfsh_sched #(
   parameter int unsigned TIMER_W   = 12,
   parameter int unsigned ROW_CNT_W = 3,
   parameter int unsigned PEND_W    = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cfg_sdr_en,
   input  logic [TIMER_W-1:0]   cfg_sdr_rfsh,
   input  logic [ROW_CNT_W-1:0] cfg_sdr_rfmax,
   sdrc_rfsh_sched_if.master    rf
);
   localparam int unsigned CMP_W   = (PEND_W > ROW_CNT_W) ? PEND_W : ROW_CNT_W;
   localparam int unsigned TOTAL_W = 16;

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [PEND_W-1:0]    pend_q, pend_d;
   logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [ROW_CNT_W-1:0] burst_len_q, burst_len_d;
   logic                 ovf_q, ovf_d;

   logic [ROW_CNT_W-1:0] rfmax_eff;
   logic                 urgent;
   logic                 expiry;
   logic                 ack_acc;
   logic                 last_ack;

   // Decodes shared by the next-state logic and the outputs.
   always_comb begin
      rfmax_eff = (cfg_sdr_rfmax == '0) ? ROW_CNT_W'(1) : cfg_sdr_rfmax;
      urgent    = CMP_W'(pend_q) >= CMP_W'(rfmax_eff);
      expiry    = (cfg_sdr_rfsh != '0) && (timer_q == TIMER_W'(1));
      ack_acc   = (state_q == ST_ACTIVE) && rf.rfsh_ack;
      last_ack  = (row_cnt_q + ROW_CNT_W'(1)) == burst_len_q;
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      pend_d      = pend_q;
      row_cnt_d   = row_cnt_q;
      burst_len_d = burst_len_q;
      ovf_d       = ovf_q;

      if (cfg_sdr_rfsh == '0)
         timer_d = '0;
      else if (timer_q <= TIMER_W'(1))
         timer_d = cfg_sdr_rfsh;
      else
         timer_d = timer_q - TIMER_W'(1);

      // Simultaneous expiry and ack cancel out.
      case ({expiry, ack_acc})
         2'b10:   if (pend_q != '1) pend_d = pend_q + PEND_W'(1);
         2'b01:   if (pend_q != '0) pend_d = pend_q - PEND_W'(1);
         default: pend_d = pend_q;
      endcase
      if (expiry && (pend_q == '1))
         ovf_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if ((pend_q != '0) && (rf.bus_idle || urgent)) begin
               state_d     = ST_ACTIVE;
               row_cnt_d   = '0;
               burst_len_d = (CMP_W'(pend_q) < CMP_W'(rfmax_eff)) ?
                             ROW_CNT_W'(pend_q) : rfmax_eff;
            end
         end
         ST_ACTIVE: begin
            if (ack_acc) begin
               if (last_ack) begin
                  state_d   = ST_IDLE;
                  row_cnt_d = '0;
               end else begin
                  row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Controller not initialised: same clear action as reset.
      if (!cfg_sdr_en) begin
         state_d     = ST_IDLE;
         timer_d     = '0;
         pend_d      = '0;
         row_cnt_d   = '0;
         burst_len_d = '0;
         ovf_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         pend_q      <= '0;
         row_cnt_q   <= '0;
         burst_len_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         pend_q      <= pend_d;
         row_cnt_q   <= row_cnt_d;
         burst_len_q <= burst_len_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef SDRC_RFSH_STATS_EN
   logic [TOTAL_W-1:0] total_q, total_d;

   // Saturating count of every accepted refresh ack.
   always_comb begin
      total_d = total_q;
      if (!cfg_sdr_en)
         total_d = '0;
      else if (ack_acc && (total_q != '1))
         total_d = total_q + TOTAL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) total_q <= '0;
      else          total_q <= total_d;
   end

   assign rf.rfsh_total = total_q;
`else
   assign rf.rfsh_total = TOTAL_W'(0);
`endif

   assign rf.rfsh_req     = (state_q == ST_ACTIVE);
   assign rf.rfsh_urgent  = urgent;
   assign rf.rfsh_pend    = pend_q;
   assign rf.rfsh_row_cnt = row_cnt_q;
   assign rf.rfsh_timer   = timer_q;
   assign rf.rfsh_ovf     = ovf_q;
endmodule

// File: tb/tb_sdrc_rfsh_sched.sv
// Self-checking bench for sdrc_rfsh_sched against a cycle-count based reference
// model; honours SDRC_RFSH_STATS_EN the same way the design does.
module tb_sdrc_rfsh_sched;
   localparam int unsigned TIMER_W   = 12;
   localparam int unsigned ROW_CNT_W = 3;
   localparam int unsigned PEND_W    = 4;
   localparam int          PEND_MAX  = (1 << PEND_W) - 1;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 cfg_sdr_en;
   logic [TIMER_W-1:0]   cfg_sdr_rfsh;
   logic [ROW_CNT_W-1:0] cfg_sdr_rfmax;

   sdrc_rfsh_sched_if #(.TIMER_W(TIMER_W), .ROW_CNT_W(ROW_CNT_W), .PEND_W(PEND_W)) rf ();

   sdrc_rfsh_sched #(.TIMER_W(TIMER_W), .ROW_CNT_W(ROW_CNT_W), .PEND_W(PEND_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cfg_sdr_en    (cfg_sdr_en),
      .cfg_sdr_rfsh  (cfg_sdr_rfsh),
      .cfg_sdr_rfmax (cfg_sdr_rfmax),
      .rf            (rf.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: cycles since enable, owed credits, burst progress.
   int m_n, m_pend, m_ovf, m_active, m_burst, m_done, m_total;
   int act_age;

   logic [37:0] dut_vec;
   logic [37:0] got, exp_v;
   assign dut_vec = {rf.rfsh_req, rf.rfsh_urgent, rf.rfsh_pend, rf.rfsh_row_cnt,
                     rf.rfsh_timer, rf.rfsh_ovf, rf.rfsh_total};

   function automatic logic [37:0] exp_vec();
      int r, rmx, tmr;
      r   = int'(cfg_sdr_rfsh);
      rmx = (cfg_sdr_rfmax == '0) ? 1 : int'(cfg_sdr_rfmax);
      tmr = (r == 0 || m_n == 0) ? 0 : r - ((m_n - 1) % r);
      return {(m_active != 0), (m_pend >= rmx), PEND_W'(m_pend), ROW_CNT_W'(m_done),
              TIMER_W'(tmr), (m_ovf != 0), 16'(m_total)};
   endfunction

   // Drive one cycle of inputs, advance the model, land on the next negedge.
   task automatic tick(input logic en, input logic rst, input logic idle, input logic ack);
      int r, rmx, old;
      bit ex, acc;
      reset_n     = rst;
      cfg_sdr_en  = en;
      rf.bus_idle = idle;
      rf.rfsh_ack = ack;
      if (!rst || !en) begin
         m_n = 0; m_pend = 0; m_ovf = 0; m_active = 0; m_burst = 0; m_done = 0; m_total = 0;
      end else begin
         r   = int'(cfg_sdr_rfsh);
         rmx = (cfg_sdr_rfmax == '0) ? 1 : int'(cfg_sdr_rfmax);
         ex  = (r != 0) && (m_n > 0) && ((m_n % r) == 0);
         acc = (m_active != 0) && ack;
         old = m_pend;
         if (ex && m_pend == PEND_MAX) m_ovf = 1;
         m_pend = m_pend + (ex ? 1 : 0) - (acc ? 1 : 0);
         if (m_pend > PEND_MAX) m_pend = PEND_MAX;
         if (m_pend < 0)        m_pend = 0;
         if (acc) begin
`ifdef SDRC_RFSH_STATS_EN
            if (m_total < 65535) m_total++;
`endif
            m_done++;
            if (m_done == m_burst) begin
               m_active = 0;
               m_done   = 0;
            end
         end else if (m_active == 0 && old != 0 && (idle || old >= rmx)) begin
            m_active = 1;
            m_burst  = (old < rmx) ? old : rmx;
            m_done   = 0;
         end
         m_n++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      cfg_sdr_rfsh  = 12'd100;
      cfg_sdr_rfmax = 3'd4;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0);
         checks++;
         if (dut_vec !== 38'h0) begin
            failures++;
            $display("FAIL reset_zero cyc=%0d got=%h exp=%h", i, dut_vec, 38'h0);
         end
      end
      for (int i = 0; i < 100; i++) begin
         tick(1'b1, 1'b1, 1'b0, 1'b0);
         got = dut_vec; exp_v = exp_vec();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, got, exp_v);
         end
      end
      checks++;
      if (rf.rfsh_pend !== 4'd0 || rf.rfsh_timer !== 12'd1) begin
         failures++;
         $display("FAIL first_expiry_pre got pend=%0d timer=%0d exp pend=0 timer=1",
                  rf.rfsh_pend, rf.rfsh_timer);
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (rf.rfsh_pend !== 4'd1 || rf.rfsh_timer !== 12'd100) begin
         failures++;
         $display("FAIL first_expiry got pend=%0d timer=%0d exp pend=1 timer=100",
                  rf.rfsh_pend, rf.rfsh_timer);
      end
   endtask

   task automatic test_periodic();
      cfg_sdr_rfsh  = 12'd100;
      cfg_sdr_rfmax = 3'd4;
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      act_age = 0;
      for (int i = 0; i < 320; i++) begin
         tick(1'b1, 1'b1, 1'b1, (m_active != 0) && act_age == 3);
         act_age = (m_active != 0) ? act_age + 1 : 0;
         got = dut_vec; exp_v = exp_vec();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL periodic cyc=%0d got=%h exp=%h", i, got, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      cfg_sdr_rfsh  = 12'd100;
      cfg_sdr_rfmax = 3'd4;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 460; i++) begin
         tick(1'b1, 1'b1, 1'b0, (i >= 450 && i < 454) ? 1'b1 : 1'b0);
         got = dut_vec; exp_v = exp_vec();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL urgent_burst cyc=%0d got=%h exp=%h", i, got, exp_v);
         end
      end
      checks++;
      if (rf.rfsh_req !== 1'b0 || rf.rfsh_pend !== 4'd0 || rf.rfsh_row_cnt !== 3'd0) begin
         failures++;
         $display("FAIL urgent_done got req=%b pend=%0d row=%0d exp req=0 pend=0 row=0",
                  rf.rfsh_req, rf.rfsh_pend, rf.rfsh_row_cnt);
      end
   endtask

   task automatic test_ovf();
      cfg_sdr_rfsh  = 12'd10;
      cfg_sdr_rfmax = 3'd1;
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 170; i++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b0);
         got = dut_vec; exp_v = exp_vec();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL ovf cyc=%0d got=%h exp=%h", i, got, exp_v);
         end
      end
      checks++;
      if (rf.rfsh_ovf !== 1'b1 || rf.rfsh_pend !== 4'd15 || rf.rfsh_req !== 1'b1) begin
         failures++;
         $display("FAIL ovf_final got ovf=%b pend=%0d req=%b exp ovf=1 pend=15 req=1",
                  rf.rfsh_ovf, rf.rfsh_pend, rf.rfsh_req);
      end
   endtask

   task automatic test_mid_reset();
      cfg_sdr_rfsh  = 12'd10;
      cfg_sdr_rfmax = 3'd4;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 46; i++) begin
         tick(1'b1, 1'b1, 1'b0, (i == 45) ? 1'b1 : 1'b0);
         got = dut_vec; exp_v = exp_vec();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL mid_reset_setup cyc=%0d got=%h exp=%h", i, got, exp_v);
         end
      end
      checks++;
      if (rf.rfsh_pend !== 4'd3 || rf.rfsh_row_cnt !== 3'd1 || rf.rfsh_req !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_pre got pend=%0d row=%0d req=%b exp pend=3 row=1 req=1",
                  rf.rfsh_pend, rf.rfsh_row_cnt, rf.rfsh_req);
      end
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== 38'h0) begin
         failures++;
         $display("FAIL mid_reset got=%h exp=%h", dut_vec, 38'h0);
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      got = dut_vec; exp_v = exp_vec();
      checks++;
      if (got !== exp_v) begin
         failures++;
         $display("FAIL mid_reset_after got=%h exp=%h", got, exp_v);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 6; s++) begin
         cfg_sdr_rfsh  = TIMER_W'($urandom_range(0, 20));
         cfg_sdr_rfmax = ROW_CNT_W'($urandom_range(0, 7));
         tick(1'b0, 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'b1, 1'($urandom % 2), 1'(($urandom % 3) != 0));
            got = dut_vec; exp_v = exp_vec();
            checks++;
            if (got !== exp_v) begin
               failures++;
               $display("FAIL random s=%0d cyc=%0d rfsh=%0d rfmax=%0d got=%h exp=%h",
                        s, i, cfg_sdr_rfsh, cfg_sdr_rfmax, got, exp_v);
            end
         end
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      cfg_sdr_en    = 1'b0;
      cfg_sdr_rfsh  = '0;
      cfg_sdr_rfmax = '0;
      rf.bus_idle   = 1'b0;
      rf.rfsh_ack   = 1'b0;
      m_n = 0; m_pend = 0; m_ovf = 0; m_active = 0; m_burst = 0; m_done = 0; m_total = 0;
      act_age = 0;
      @(negedge clk);
      test_reset();
      test_periodic();
      test_back_to_back();
      test_ovf();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
